// File: rtl/reg_file.sv
// reg_file: flip-flop register file, two combinational read ports, one synchronous write port
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic [AW-1:0]         ra,
  input  logic [AW-1:0]         rb,
  input  logic [AW-1:0]         rd,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] qa,
  output logic [DATA_WIDTH-1:0] qb
);
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++)
      regs_d[i] = (we && rd == AW'(i)) ? d : regs_q[i];
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++)
      regs_q[i] <= rst ? '0 : regs_d[i];
  end
  assign qa = (int'(ra) < NUM_REGS) ? regs_q[ra] : '0;
  assign qb = (int'(rb) < NUM_REGS) ? regs_q[rb] : '0;
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: randomized scoreboard bench for reg_file against an array reference model
module tb_reg_file;
  logic        clk, rst, we;
  logic [31:0] d, qa, qb;
  logic [4:0]  ra, rb, rd;
  logic [31:0] mdl [32];
  logic [63:0] exp_q [$];
  string       tag_q [$];
  int          compared = 0;
  int          mismatched = 0;

  reg_file dut (.clk(clk), .rst(rst), .d(d), .ra(ra), .rb(rb), .rd(rd), .we(we), .qa(qa), .qb(qb));

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    if (exp_q.size() != 0) begin
      logic [63:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      compared++;
      if ({qa, qb} !== e) begin
        mismatched++;
        $display("FAIL %s: ra=%0d rb=%0d got qa=%h qb=%h expected qa=%h qb=%h",
                 t, ra, rb, qa, qb, e[63:32], e[31:0]);
      end
    end
  end

  task automatic step(input logic r, input logic w, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] c, input logic [31:0] dd, input bit chk, input string tag);
    rst = r; we = w; ra = a; rb = b; rd = c; d = dd;
    if (chk) begin
      exp_q.push_back({mdl[a], mdl[b]});
      tag_q.push_back(tag);
    end
    if (r) foreach (mdl[i]) mdl[i] = '0;
    else if (w) mdl[c] = dd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 0; rst = 0; we = 0; ra = 0; rb = 0; rd = 0; d = 0;
    foreach (mdl[i]) mdl[i] = 'x;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0, 0, "init");
    for (int i = 0; i < 20; i++)
      step(0, 1, 0, 0, 5'($urandom), $urandom, 0, "prewrite");
    step(1, 0, 0, 0, 0, 0, 0, "reset");
    for (int i = 0; i < 32; i++)
      step(0, 0, 5'(i), 5'(31 - i), 0, 0, 1, "reset_zero");
    for (int i = 0; i < 32; i++)
      step(0, 1, 0, 0, 5'(i), 32'(i), 0, "fill");
    for (int i = 0; i < 32; i++)
      step(0, 0, 5'(i), 5'(31 - i), 0, 0, 1, "fill_sweep");
    for (int i = 0; i < 10; i++)
      step(0, 0, 5, 5, 5, 32'hDEADBEEF, 1, "we0_guard");
    step(0, 1, 7, 7, 7, 32'hA5A5A5A5, 1, "rdw_before");
    step(0, 0, 7, 7, 7, 0, 1, "rdw_after");
    step(1, 1, 3, 3, 3, 32'h1234, 1, "rst_prio_before");
    step(0, 0, 3, 7, 0, 0, 1, "rst_prio_after");
    for (int i = 0; i < 100; i++)
      step(0, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, 1, "random");
    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
